// File: rtl/fpu_pkg.sv
// fpu_pkg: rounding modes, canonical constants, flag layout and FSM state type
package fpu_pkg;
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_t;
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) n = v[i] ? 5'(23 - i) : n;
    return n;
  endfunction
  function automatic logic [4:0] mk_flags(input logic nv, input logic nx);
    logic [4:0] f;
    f = '0;
    f[FF_NV] = nv;
    f[FF_NX] = nx;
    return f;
  endfunction
endpackage

// File: rtl/sqrt_rounder.sv
// sqrt_rounder: round-up decision from {L,G,R,S}, rounding mode and sign
module sqrt_rounder import fpu_pkg::*; (
  input  logic [3:0] lgrs,
  input  logic [2:0] rm,
  input  logic       sign,
  output logic       round_up
);
  logic inexact;
  assign inexact = |lgrs[2:0];
  always_comb begin
    case (rm)
      RM_RNE:  round_up = lgrs[2] & (lgrs[3] | lgrs[1] | lgrs[0]);
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = sign & inexact;
      RM_RUP:  round_up = ~sign & inexact;
      RM_RMM:  round_up = lgrs[2];
      default: round_up = 1'b0;
    endcase
  end
endmodule

// File: rtl/fsqrt_ctrl.sv
// fsqrt_ctrl: iterative binary32 square root, restoring radix-2 recurrence
// Define FSQRT_EARLY_SPECIAL_EN to send special operands straight PREP -> DONE.
module fsqrt_ctrl import fpu_pkg::*; #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic        ready_o,
  input  logic [31:0] operand_i,
  input  logic [2:0]  rm_i,
  input  logic        flush_i,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  fflags_o
);
  localparam int ITERS = 26 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST = 5'(ITERS - 1);
  state_t state_q, state_d;
  logic [31:0] op_q, spec_res_q;
  logic [2:0] rm_q;
  logic [51:0] rad_q, rad_d;
  logic [27:0] rem_q, rem_d;
  logic [25:0] root_q, root_d;
  logic [7:0] exp_q;
  logic [4:0] cnt_q;
  logic spec_q, nv_q;
  logic [7:0] e_in;
  logic [22:0] f_in;
  logic sgn, is_zero, is_inf, is_nan, is_special, sp_nv;
  logic [31:0] sp_res;
  logic [23:0] mant, norm;
  logic [4:0] lz;
  logic [9:0] uexp;
  logic [7:0] exp_m1;
  logic [24:0] rad_hi;
  logic [29:0] acc, trial;
  logic rb, nx;
  logic [31:0] rnd_res;
  assign sgn = op_q[31];
  assign e_in = op_q[30:23];
  assign f_in = op_q[22:0];
  assign is_zero = (e_in == 8'd0) && (f_in == 23'd0);
  assign is_inf = (&e_in) && (f_in == 23'd0);
  assign is_nan = (&e_in) && (|f_in);
  assign is_special = is_zero | is_inf | is_nan | sgn;
  assign sp_res = is_zero ? op_q : (is_nan | sgn) ? CANON_NAN : POS_INF;
  assign sp_nv = is_nan ? ~f_in[22] : sgn & ~is_zero;
  assign mant = {|e_in, f_in};
  assign lz = lzc24(mant);
  assign norm = mant << lz;
  assign uexp = {2'b00, (|e_in) ? e_in : 8'd1} - 10'd127 - {5'd0, lz};
  // Stored one below the true exponent: the root's leading 1 carries into it.
  assign exp_m1 = 8'({uexp[9], uexp[9:1]} + 10'd126);
  assign rad_hi = uexp[0] ? {norm, 1'b0} : {1'b0, norm};
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start_i ? S_PREP : S_IDLE;
`ifdef FSQRT_EARLY_SPECIAL_EN
      S_PREP:  state_d = is_special ? S_DONE : S_ITER;
`else
      S_PREP:  state_d = S_ITER;
`endif
      S_ITER:  state_d = (cnt_q == LAST) ? S_ROUND : S_ITER;
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = result_ready_i ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end
  always_comb begin
    ready_o = state_q == S_IDLE;
    result_valid_o = state_q == S_DONE;
  end
  always_comb begin
    rem_d = rem_q;
    root_d = root_q;
    rad_d = rad_q;
    acc = '0;
    trial = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      acc = {rem_d, rad_d[51:50]};
      trial = {2'b00, root_d, 2'b01};
      rem_d = (acc >= trial) ? 28'(acc - trial) : acc[27:0];
      root_d = {root_d[24:0], acc >= trial};
      rad_d = {rad_d[49:0], 2'b00};
    end
  end
  sqrt_rounder u_rounder (
    .lgrs     ({root_q[2:0], |rem_q}),
    .rm       (rm_q),
    .sign     (sgn),
    .round_up (rb)
  );
  assign nx = |root_q[1:0] | |rem_q;
  assign rnd_res = {1'b0, exp_q, 23'd0} + {8'd0, root_q[25:2]} + {31'd0, rb};
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q <= '0;
      rm_q <= '0;
      rad_q <= '0;
      rem_q <= '0;
      root_q <= '0;
      exp_q <= '0;
      cnt_q <= '0;
      spec_q <= 1'b0;
      nv_q <= 1'b0;
      spec_res_q <= '0;
    end else begin
      if (state_q == S_IDLE && start_i && !flush_i) begin
        op_q <= operand_i;
        rm_q <= rm_i;
      end
      if (state_q == S_PREP) begin
        rad_q <= {rad_hi, 27'd0};
        rem_q <= '0;
        root_q <= '0;
        cnt_q <= '0;
        exp_q <= exp_m1;
        spec_q <= is_special;
        nv_q <= sp_nv;
        spec_res_q <= sp_res;
      end
      if (state_q == S_ITER) begin
        rad_q <= rad_d;
        rem_q <= rem_d;
        root_q <= root_d;
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      result_o <= '0;
      fflags_o <= '0;
    end else if (!flush_i && state_q == S_ROUND) begin
      result_o <= spec_q ? spec_res_q : rnd_res;
      fflags_o <= mk_flags(spec_q & nv_q, ~spec_q & nx);
    end
`ifdef FSQRT_EARLY_SPECIAL_EN
    else if (!flush_i && state_q == S_PREP && is_special) begin
      result_o <= sp_res;
      fflags_o <= mk_flags(sp_nv, 1'b0);
    end
`endif
  end
endmodule

// File: doc/fsqrt_ctrl.md
FSQRT_CTRL -- requirements
Module: fsqrt_ctrl

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 1, root bits resolved per ITER cycle (legal values 1 or 2).
REQ-002 SHALL have port clk_i  in  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_i  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port start_i  in  1  request valid.
REQ-005 SHALL have port ready_o  out  1  able to accept a request.
REQ-006 SHALL have port operand_i  in  32  IEEE-754 binary32 operand.
REQ-007 SHALL have port rm_i  in  3  resolved rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others invalid).
REQ-008 SHALL have port flush_i  in  1  abort the operation in flight.
REQ-009 SHALL have port result_valid_o  out  1  result available.
REQ-010 SHALL have port result_ready_i  in  1  consumer accepts the result.
REQ-011 SHALL have port result_o  out  32  rounded square root.
REQ-012 SHALL have port fflags_o  out  5  {NV,DZ,OF,UF,NX}; only NV and NX are ever set.

Function
REQ-013 SHALL implement FSM IDLE -> PREP -> ITER -> ROUND -> DONE -> IDLE; ready_o=1 only in IDLE.
REQ-014 SHALL accept a request at the edge where start_i&ready_o=1, latching operand_i and rm_i; start_i in any other state is ignored.
REQ-015 PREP (1 cycle) SHALL classify the operand, normalise subnormals with a single-cycle leading-zero count, unbias the exponent, and pre-shift the mantissa left 1 when the unbiased exponent is odd.
REQ-016 ITER SHALL run restoring radix-2 digit recurrence for 26/BITS_PER_CYCLE cycles, producing 24 root bits plus G and R; S = (final remainder != 0).
REQ-017 Result exponent SHALL be floor(unbiased_exp/2)+127; +0.0 and -0.0 SHALL return the same value unchanged with no flags.
REQ-018 ROUND (1 cycle) SHALL add the round bit (RNE/RMM: G; RTZ: 0; RUP: |{G,R,S}| when positive; RDN: 0 when positive; invalid rm: 0) and increment the exponent on mantissa carry-out.
REQ-019 NX SHALL equal |{G,R,S}| for finite nonzero results.
REQ-020 Negative nonzero operand (including -inf), or any NaN, SHALL return 0x7FC00000; NV=1 for negative operands and sNaN, NV=0 for qNaN.
REQ-021 +inf SHALL return 0x7F800000 with no flags.
REQ-022 DONE SHALL hold result_valid_o=1 with result_o/fflags_o stable until result_ready_i=1, then return to IDLE on that edge.
REQ-023 Total latency with BITS_PER_CYCLE=1 SHALL be 29 cycles (accept edge to first cycle valid is high); with BITS_PER_CYCLE=2, 16 cycles.
REQ-024 flush_i=1 SHALL force IDLE on the next edge from any state, discard the result, and block acceptance on that edge; flush_i takes priority over start_i and result_ready_i.

Reset
REQ-025 reset_i SHALL force IDLE, ready_o=1, result_valid_o=0, result_o=0, fflags_o=0 and clear the iteration counter, including mid-operation.

Configuration
REQ-026 With FSQRT_EARLY_SPECIAL_EN defined, special operands (zero, inf, NaN, negative) SHALL go PREP -> DONE, giving a latency of 2 cycles.
REQ-027 Without FSQRT_EARLY_SPECIAL_EN, all operands SHALL traverse ITER and ROUND, giving a fixed latency per REQ-023 with identical results.

Structure
REQ-028 Package fpu_pkg SHALL hold the rounding-mode constants, the canonical NaN 0x7FC00000, the fflags bit indices, and the FSM state typedef.
REQ-029 The round-bit decision SHALL be one sub-module, sqrt_rounder (inputs {L,G,R,S}, rm, sign; output round bit), instantiated once.

Verification
REQ-030 operand 0x40800000 (4.0), rm RNE -> 0x40000000, fflags 0, valid at cycle 29.
REQ-031 operand 0x40000000 (2.0): RNE -> 0x3FB504F3, NX=1; RUP -> 0x3FB504F4; RTZ -> 0x3FB504F3.
REQ-032 operand 0xBF800000 -> 0x7FC00000, NV=1; operand 0x7FC00000 -> 0x7FC00000, NV=0; operand 0x80000000 -> 0x80000000; operand 0x7F800000 -> 0x7F800000.
REQ-033 operand 0x00000001 (min subnormal) -> 0x1A3504F3, NX=1; operand 0x7F7FFFFF, RUP -> 0x5F800000, NX=1 (exponent carry on rounding).
REQ-034 result_ready_i held 0 for 10 cycles -> result_o stable, ready_o=0; flush_i asserted in ITER -> IDLE next cycle, no valid; reset_i pulsed mid-ITER -> all outputs at reset values.
REQ-035 Back-to-back: new start_i in the cycle after DONE handshake -> accepted, second result correct, no stale flags.
